pbs_digit_recomposer: RTL

Streaming recomposer that rebuilds a modular coefficient from its signed, balanced decomposition digits. It is the inverse of the gadget decomposer used ahead of the key-switch and PBS external products. Its main uses are:
- closing the decompose/recompose loop in the datapath;
- on-chip self-check of the decomposer;
- the result path of the key-switch accumulator.

It accepts one digit per cycle on a valid/ready stream and emits one recomposed coefficient per L digits, with backpressure.

---
 rtl/pbs_digit_recomposer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pbs_digit_recomposer.sv
// Streaming recomposer: rebuilds an OP_W-bit coefficient from L signed balanced digits (MSB level first).
// Optional framing/range checker enabled by defining PBS_RECOMP_CHECK_EN.
module pbs_digit_recomposer #(
    parameter int OP_W = 64,
    parameter int B_W  = 3,
    parameter int L    = 5,
    parameter int ID_W = 8
) (
    input  logic            clk,
    input  logic            s_rst,
    input  logic [B_W:0]    in_digit,
    input  logic            in_last,
    input  logic [ID_W-1:0] in_id,
    input  logic            in_vld,
    output logic            in_rdy,
    output logic [OP_W-1:0] out_data,
    output logic [ID_W-1:0] out_id,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic            err,
    output logic            err_sticky
);

    localparam int LVL_W = $clog2(L + 1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_L   = LVL_W'(L);

    generate
        if (L * B_W > OP_W) begin : g_bad_cfg
            $error("pbs_digit_recomposer: L*B_W must not exceed OP_W");
        end
    endgenerate

    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [OP_W-1:0]  acc_q, acc_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [OP_W-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic             out_vld_q, out_vld_d;

    logic             accept, first_lvl, final_lvl;
    logic signed [B_W:0] dig_s;
    logic [OP_W-1:0]  dig_ext, term, sum;
    int               shamt;

    assign in_rdy = (lvl_q != LVL_L) | ~out_vld_q | out_rdy;

    always_comb begin
        accept    = in_vld & in_rdy;
        first_lvl = (lvl_q == LVL_ONE);
        final_lvl = (lvl_q == LVL_L);
        dig_s     = in_digit;
        dig_ext   = OP_W'(dig_s);
        shamt     = OP_W - int'(lvl_q) * B_W;
        term      = dig_ext << shamt;
        // Level 1 loads the accumulator so a new coefficient never sees stale partial sums.
        sum       = first_lvl ? term : acc_q + term;
    end

    always_comb begin
        lvl_d      = lvl_q;
        acc_d      = acc_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_vld_d  = out_vld_q & ~out_rdy;
        if (accept) begin
            acc_d = sum;
            if (first_lvl) id_d = in_id;
            if (final_lvl) begin
                out_data_d = sum;
                out_id_d   = first_lvl ? in_id : id_q;
                out_vld_d  = 1'b1;
                lvl_d      = LVL_ONE;
            end else begin
                lvl_d = lvl_q + LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            lvl_q      <= LVL_ONE;
            acc_q      <= '0;
            id_q       <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            acc_q      <= acc_d;
            id_q       <= id_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_data = out_data_q;
    assign out_id   = out_id_q;
    assign out_vld  = out_vld_q;

`ifdef PBS_RECOMP_CHECK_EN
    logic err_q, err_sticky_q, bad_beat;

    // Balanced digits span [-B/2, B/2] inclusive; in_last must coincide with the counter's final level.
    always_comb begin
        bad_beat = (in_last != final_lvl)
                 | (int'(dig_s) < -(2 ** (B_W - 1)))
                 | (int'(dig_s) >  (2 ** (B_W - 1)));
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            err_q        <= accept & bad_beat;
            err_sticky_q <= err_sticky_q | (accept & bad_beat);
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign err        = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule
